// File: rtl/nn_pkg.sv
// Shared definitions for the nn core memory subsystem: RAM geometry, requester
// port indices and the peripheral address map used by the upstream decoder.
package nn_pkg;

    localparam int RAM_SIZE   = 1024;
    localparam int RAM_ADDR_W = 10;
    localparam int N_PORTS    = 3;

    typedef enum logic [1:0] {
        PORT_D = 2'd0,
        PORT_F = 2'd1,
        PORT_H = 2'd2
    } port_e;

    // Peripheral window; these addresses are steered away before the arbiter.
    localparam logic [31:0] PF_KEY = 32'hFFFF_0000;
    localparam logic [31:0] PF_LED = 32'hFFFF_0004;
    localparam logic [31:0] PF_VGA = 32'hFFFF_8000;

    // Reduces ptr+offset (0..5) modulo the number of ports.
    function automatic port_e port_wrap(input logic [2:0] v);
        case (v)
            3'd0, 3'd3: return PORT_D;
            3'd1, 3'd4: return PORT_F;
            default:    return PORT_H;
        endcase
    endfunction

    function automatic port_e port_next(input port_e k);
        return port_wrap(3'(k) + 3'd1);
    endfunction

endpackage

// File: rtl/nn_mem_arbiter_if.sv
// One requester-side RAM access port: request/accept handshake plus the
// registered read response and error strobe.
interface nn_mem_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata, err);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/nn_rr_pick3.sv
// Combinational 3-way round-robin selector: starting at ptr, the first eligible
// port wins and is reported as a one-hot grant.
module nn_rr_pick3
    import nn_pkg::*;
(
    input  logic [2:0] eligible,
    input  port_e      ptr,
    output logic [2:0] grant,
    output logic       valid
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        grant = '0;
        valid = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (!valid && eligible[port_wrap(3'(ptr) + 3'(i))]) begin
                grant[port_wrap(3'(ptr) + 3'(i))] = 1'b1;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nn_mem_arbiter.sv
// Round-robin arbiter sharing the single-port word RAM between CPU data,
// CPU fetch and host loader ports, with a one-cycle registered read response.
module nn_mem_arbiter
    import nn_pkg::*;
#(
    parameter int RAM_WORDS = RAM_SIZE,
    parameter int ADDR_W    = RAM_ADDR_W
) (
    input  logic                CLK,
    input  logic                RST_N,
    nn_mem_arbiter_if.slave     d,
    nn_mem_arbiter_if.slave     f,
    nn_mem_arbiter_if.slave     h,
    input  logic                h_lock,
    output logic                ram_en,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [31:0]         ram_wdata,
    input  logic [31:0]         ram_rdata
);

    if (RAM_WORDS != 2 ** ADDR_W) begin : g_bad_depth
        $error("nn_mem_arbiter: RAM_WORDS must equal 2**ADDR_W");
    end

    logic [2:0]  req_v;
    logic [2:0]  eligible;
    logic [2:0]  grant;
    logic        grant_valid;
    port_e       ptr;
    port_e       ptr_nxt;
    port_e       win;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_oor;
    logic        unused_addr_lsb;

    logic        rsp_valid;
    logic        rsp_err;
    logic        rsp_zero;
    port_e       rsp_owner;
    logic        rsp_live;
    logic        err_live;

    // Reset blocks grants combinationally so nothing reaches the RAM while held.
    assign req_v    = {h.req, f.req, d.req};
    assign eligible = !RST_N ? 3'b000 : (h_lock ? {h.req, 2'b00} : req_v);

    nn_rr_pick3 u_pick (
        .eligible (eligible),
        .ptr      (ptr),
        .grant    (grant),
        .valid    (grant_valid)
    );

    assign d.gnt = grant[PORT_D];
    assign f.gnt = grant[PORT_F];
    assign h.gnt = grant[PORT_H];

    always_comb begin
        win       = PORT_D;
        sel_we    = d.we;
        sel_addr  = d.addr;
        sel_wdata = d.wdata;
        if (grant[PORT_F]) begin
            win       = PORT_F;
            sel_we    = f.we;
            sel_addr  = f.addr;
            sel_wdata = f.wdata;
        end else if (grant[PORT_H]) begin
            win       = PORT_H;
            sel_we    = h.we;
            sel_addr  = h.addr;
            sel_wdata = h.wdata;
        end
    end

    // Word access only; the byte offset is deliberately ignored.
    assign unused_addr_lsb = ^sel_addr[1:0];
    assign sel_oor   = |sel_addr[31:ADDR_W+2];
    assign ram_en    = grant_valid & ~sel_oor;
    assign ram_we    = ram_en & sel_we;
    assign ram_addr  = sel_addr[ADDR_W+1:2];
    assign ram_wdata = sel_wdata;

    always_comb begin
        ptr_nxt = ptr;
        if (grant_valid) begin
            ptr_nxt = port_next(win);
        end
    end

    // NOTE: state registers use non-blocking assignments; reset is synchronous, sampled on CLK.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ptr       <= PORT_D;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            ptr       <= ptr_nxt;
            rsp_valid <= grant_valid & ~sel_we;
            rsp_err   <= grant_valid & sel_oor;
        end
    end

    // NOTE: owner/zero are pure payload, only consumed when rsp_valid/rsp_err are set, so no reset.
    always_ff @(posedge CLK) begin
        rsp_owner <= win;
        rsp_zero  <= sel_oor;
    end

    // A response launched just before reset is suppressed while reset is held.
    assign rsp_live = rsp_valid & RST_N;
    assign err_live = rsp_err & RST_N;

    assign d.rvalid = rsp_live & (rsp_owner == PORT_D);
    assign f.rvalid = rsp_live & (rsp_owner == PORT_F);
    assign h.rvalid = rsp_live & (rsp_owner == PORT_H);

    assign d.rdata = (rsp_live && rsp_owner == PORT_D && !rsp_zero) ? ram_rdata : 32'h0;
    assign f.rdata = (rsp_live && rsp_owner == PORT_F && !rsp_zero) ? ram_rdata : 32'h0;
    assign h.rdata = (rsp_live && rsp_owner == PORT_H && !rsp_zero) ? ram_rdata : 32'h0;

    assign d.err = err_live & (rsp_owner == PORT_D);
    assign f.err = err_live & (rsp_owner == PORT_F);
    assign h.err = err_live & (rsp_owner == PORT_H);

endmodule

// File: tb/tb_nn_mem_arbiter.sv
// Directed bench for nn_mem_arbiter: fairness, write/read ordering, out-of-range,
// host lock, reset mid-flight and single-requester streaming against a RAM model.
module tb_nn_mem_arbiter;

    localparam int ADDR_W = 10;

    logic              CLK;
    logic              RST_N;
    logic              h_lock;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic [31:0]       mem [1024];

    int n_checks = 0;
    int n_fail   = 0;

    nn_mem_arbiter_if d_if ();
    nn_mem_arbiter_if f_if ();
    nn_mem_arbiter_if h_if ();

    nn_mem_arbiter #(.RAM_WORDS(1024), .ADDR_W(ADDR_W)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .d         (d_if),
        .f         (f_if),
        .h         (h_if),
        .h_lock    (h_lock),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | i;
        ram_rdata = 32'h0;
    end

    always @(posedge CLK) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input int p, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        case (p)
            0: begin d_if.req = req; d_if.we = we; d_if.addr = addr; d_if.wdata = wdata; end
            1: begin f_if.req = req; f_if.we = we; f_if.addr = addr; f_if.wdata = wdata; end
            default: begin h_if.req = req; h_if.we = we; h_if.addr = addr; h_if.wdata = wdata; end
        endcase
    endtask

    function automatic logic [31:0] gnt_v();
        return {29'h0, h_if.gnt, f_if.gnt, d_if.gnt};
    endfunction

    function automatic logic [31:0] rv_v();
        return {29'h0, h_if.rvalid, f_if.rvalid, d_if.rvalid};
    endfunction

    function automatic logic [31:0] err_v();
        return {29'h0, h_if.err, f_if.err, d_if.err};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic look();
        @(negedge CLK);
    endtask

    initial begin
        RST_N  = 1'b0;
        h_lock = 1'b0;
        drive(0, 1'b1, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h4, 32'h0);
        drive(2, 1'b1, 1'b0, 32'h8, 32'h0);

        // Reset held with every request high.
        look();
        check("rst_gnt", gnt_v(), 32'h0);
        check("rst_ram_en", {31'h0, ram_en}, 32'h0);
        check("rst_rvalid", rv_v(), 32'h0);
        tick();
        RST_N = 1'b1;

        // 1. Fairness: d, f, h, d, f, h with responses one cycle later.
        for (int c = 0; c < 6; c++) begin
            look();
            check("rr_gnt", gnt_v(), 32'h1 << (c % 3));
            check("rr_addr", {22'h0, ram_addr}, c % 3);
            if (c == 0) begin
                check("rr_rv0", rv_v(), 32'h0);
            end else begin
                check("rr_rv", rv_v(), 32'h1 << ((c - 1) % 3));
                check("rr_rdata", d_if.rdata | f_if.rdata | h_if.rdata,
                      32'hA000_0000 | ((c - 1) % 3));
            end
            tick();
        end

        // 2. Write then read of the same word.
        drive(0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
        look();
        check("wr_gnt", gnt_v(), 32'h1);
        check("wr_ram_we", {30'h0, ram_en, ram_we}, 32'h3);
        check("wr_addr", {22'h0, ram_addr}, 32'h4);
        check("wr_wdata", ram_wdata, 32'hDEAD_BEEF);
        check("wr_h_rdata", h_if.rdata, 32'hA000_0002);
        tick();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h10, 32'h0);
        look();
        check("rd_gnt", gnt_v(), 32'h2);
        check("rd_ram_we", {30'h0, ram_en, ram_we}, 32'h2);
        check("wr_no_rvalid", rv_v(), 32'h0);
        tick();
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        look();
        check("rd_rv", rv_v(), 32'h2);
        check("rd_rdata", f_if.rdata, 32'hDEAD_BEEF);
        tick();

        // 3. Out-of-range read and write.
        drive(0, 1'b1, 1'b0, 32'h8000_0000, 32'h0);
        look();
        check("oor_rd_gnt", gnt_v(), 32'h1);
        check("oor_rd_en", {31'h0, ram_en}, 32'h0);
        tick();
        drive(0, 1'b1, 1'b1, 32'h0000_1000, 32'h1234_5678);
        look();
        check("oor_wr_gnt", gnt_v(), 32'h1);
        check("oor_wr_en", {31'h0, ram_en}, 32'h0);
        check("oor_rd_rv", rv_v(), 32'h1);
        check("oor_rd_rdata", d_if.rdata, 32'h0);
        check("oor_rd_err", err_v(), 32'h1);
        tick();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(2, 1'b1, 1'b0, 32'h0, 32'h0);
        look();
        check("oor_wr_rv", rv_v(), 32'h0);
        check("oor_wr_err", err_v(), 32'h1);
        check("oor_h_gnt", gnt_v(), 32'h4);
        tick();
        drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
        look();
        check("oor_mem0_rv", rv_v(), 32'h4);
        check("oor_mem0", h_if.rdata, 32'hA000_0000);
        check("oor_err_clr", err_v(), 32'h0);
        tick();

        // 4. Host lock.
        h_lock = 1'b1;
        drive(0, 1'b1, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h4, 32'h0);
        drive(2, 1'b1, 1'b0, 32'h8, 32'h0);
        for (int c = 0; c < 5; c++) begin
            look();
            check("lock_gnt", gnt_v(), 32'h4);
            tick();
        end
        h_lock = 1'b0;
        look();
        check("unlock_gnt", gnt_v(), 32'h1);
        check("unlock_h_rv", rv_v(), 32'h4);
        check("unlock_h_rdata", h_if.rdata, 32'hA000_0002);
        tick();
        h_lock = 1'b1;
        drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
        look();
        check("lock_idle_gnt", gnt_v(), 32'h0);
        check("lock_idle_en", {31'h0, ram_en}, 32'h0);
        check("lock_inflight_rv", rv_v(), 32'h1);
        check("lock_inflight_rdata", d_if.rdata, 32'hA000_0000);
        tick();
        h_lock = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);

        // 5. Reset right after an accepted read.
        drive(1, 1'b1, 1'b0, 32'h4, 32'h0);
        look();
        check("pre_rst_gnt", gnt_v(), 32'h2);
        tick();
        RST_N = 1'b0;
        drive(0, 1'b1, 1'b0, 32'h0, 32'h0);
        drive(2, 1'b1, 1'b0, 32'h8, 32'h0);
        look();
        check("mid_rst_gnt", gnt_v(), 32'h0);
        check("mid_rst_en", {31'h0, ram_en}, 32'h0);
        check("mid_rst_rv", rv_v(), 32'h0);
        check("mid_rst_rdata", f_if.rdata, 32'h0);
        tick();
        RST_N = 1'b1;
        look();
        check("post_rst_gnt", gnt_v(), 32'h1);
        check("post_rst_rv", rv_v(), 32'h0);
        tick();

        // 6. Single requester streaming.
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 32'hC, 32'h0);
        look();
        check("solo_gnt0", gnt_v(), 32'h2);
        check("solo_d_rv", rv_v(), 32'h1);
        check("solo_d_rdata", d_if.rdata, 32'hA000_0000);
        tick();
        for (int c = 0; c < 4; c++) begin
            look();
            check("solo_gnt", gnt_v(), 32'h2);
            check("solo_rv", rv_v(), 32'h2);
            check("solo_rdata", f_if.rdata, 32'hA000_0003);
            tick();
        end
        drive(0, 1'b1, 1'b0, 32'h0, 32'h0);
        drive(2, 1'b1, 1'b0, 32'h8, 32'h0);
        look();
        check("solo_ptr2_gnt", gnt_v(), 32'h4);
        tick();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
        look();
        check("final_h_rv", rv_v(), 32'h4);
        check("final_h_rdata", h_if.rdata, 32'hA000_0002);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
